idu_scoreboard_issue: RTL and testbench



---
 rtl/idu_pkg.sv | 29 ++
 rtl/idu_pending_table.sv | 68 ++++++
 rtl/idu_scoreboard_issue.sv | 163 ++++++++++++++++
 tb/tb_idu_scoreboard_issue.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/idu_pkg.sv
// Shared types for the decode-to-execute issue stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: issue FSM state enum, default widths, bypass-port record and a
// helper giving the largest value a pending counter can hold.
package idu_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int RIDX_W_DEF = 5;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ISSUE = 2'd2
  } state_t;

  // One writeback/bypass port at default widths.
  typedef struct packed {
    logic                  valid;
    logic [RIDX_W_DEF-1:0] rd;
    logic [XLEN_DEF-1:0]   data;
  } byp_t;

  function automatic int pend_max(input int pend_w);
    return (1 << pend_w) - 1;
  endfunction

endpackage

// File: rtl/idu_pending_table.sv
// Per-register outstanding-write counters: one increment port, BYP_PORTS decrement ports.
// Latency: counts update one cycle after the increment/decrement is presented.
// Backpressure: none; callers must not increment a saturated counter or retire an idle one.
//
// Ports: i_clk/i_rst (sync, active-high); i_inc_vld/i_inc_rd (issue of a write);
// i_dec_vld/i_dec_rd (retiring writes, flattened per port);
// o_pend (flattened counters), o_busy (counter != 0), o_sat (counter at max).
module idu_pending_table
  import idu_pkg::*;
#(
  parameter int NREG      = 32,
  parameter int RIDX_W    = 5,
  parameter int BYP_PORTS = 2,
  parameter int PEND_W    = 2
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_inc_vld,
  input  logic [RIDX_W-1:0]           i_inc_rd,
  input  logic [BYP_PORTS-1:0]        i_dec_vld,
  input  logic [BYP_PORTS*RIDX_W-1:0] i_dec_rd,
  output logic [NREG*PEND_W-1:0]      o_pend,
  output logic [NREG-1:0]             o_busy,
  output logic [NREG-1:0]             o_sat
);

  localparam int PMAX = pend_max(PEND_W);

  logic [PEND_W-1:0] r_pend     [NREG];
  logic [PEND_W-1:0] w_pend_nxt [NREG];
  int                w_sum      [NREG];
  logic [NREG-1:0]   w_uflow;

  // Net change per register: +1 for an issue, -1 per retiring port.
  // Register 0 never tracks anything. Underflow clamps to 0 and is flagged.
  always_comb begin
    w_uflow = '0;
    for (int r = 0; r < NREG; r++) begin
      w_sum[r] = int'(r_pend[r]);
      if (i_inc_vld && i_inc_rd == RIDX_W'(r)) w_sum[r] = w_sum[r] + 1;
      for (int k = 0; k < BYP_PORTS; k++) begin
        if (i_dec_vld[k] && i_dec_rd[k*RIDX_W +: RIDX_W] == RIDX_W'(r)) w_sum[r] = w_sum[r] - 1;
      end
      w_uflow[r] = (r != 0) && (w_sum[r] < 0);
      if (r == 0 || w_sum[r] < 0) w_pend_nxt[r] = '0;
      else if (w_sum[r] > PMAX)   w_pend_nxt[r] = PEND_W'(PMAX);
      else                        w_pend_nxt[r] = PEND_W'(w_sum[r]);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int r = 0; r < NREG; r++) r_pend[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        r_pend[r] <= w_pend_nxt[r];
        assert (!w_uflow[r]);
      end
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_out
    assign o_pend[g*PEND_W +: PEND_W] = r_pend[g];
    assign o_busy[g] = (r_pend[g] != '0);
    assign o_sat[g]  = (r_pend[g] == PEND_W'(PMAX));
  end

endmodule

// File: rtl/idu_scoreboard_issue.sv
// Decode-to-execute issue stage: holds one instruction, resolves rs1/rs2 from regfile or bypass.
// Latency: accept at T, out_valid at T+2 at the earliest.
// Backpressure: in_ready low while an instruction waits; outputs hold while out_valid & !out_ready.
//
// Ports: clk/rst (sync, active-high); in_* decoded instruction (valid/ready);
// rf_raddr*/rf_rdata* combinational regfile read; byp_* retiring results (flattened per port);
// flush drops the held instruction; out_* resolved instruction (valid/ready); stall hazard wait.
module idu_scoreboard_issue
  import idu_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int NREG      = 32,
  parameter int RIDX_W    = RIDX_W_DEF,
  parameter int BYP_PORTS = 2,
  parameter int PEND_W    = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [RIDX_W-1:0]           in_rs1,
  input  logic [RIDX_W-1:0]           in_rs2,
  input  logic [RIDX_W-1:0]           in_rd,
  input  logic                        in_rd_we,
  input  logic [XLEN-1:0]             in_imm,
  input  logic                        in_src2_imm,
  output logic [RIDX_W-1:0]           rf_raddr1,
  output logic [RIDX_W-1:0]           rf_raddr2,
  input  logic [XLEN-1:0]             rf_rdata1,
  input  logic [XLEN-1:0]             rf_rdata2,
  input  logic [BYP_PORTS-1:0]        byp_valid,
  input  logic [BYP_PORTS*RIDX_W-1:0] byp_rd,
  input  logic [BYP_PORTS*XLEN-1:0]   byp_data,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [XLEN-1:0]             out_src1,
  output logic [XLEN-1:0]             out_src2,
  output logic [RIDX_W-1:0]           out_rd,
  output logic                        out_rd_we,
  output logic                        stall
);

  state_t            r_state, w_state_nxt;
  logic              r_out_vld;
  logic [RIDX_W-1:0] r_rs1, r_rs2, r_rd;
  logic              r_rd_we, r_src2_imm, r_got1, r_got2;
  logic [XLEN-1:0]   r_imm, r_src1, r_src2;

  logic [NREG*PEND_W-1:0] w_pend_flat;
  logic [PEND_W-1:0]      w_pend [NREG];
  logic [NREG-1:0]        w_busy, w_sat;

  logic            w_fire, w_inc, w_accept, w_go, w_rd_ok;
  logic            w_hit1, w_hit2, w_rd_dec, w_ok1, w_ok2;
  logic [XLEN-1:0] w_bdat1, w_bdat2, w_val1, w_val2;

  for (genvar g = 0; g < NREG; g++) begin : g_pend
    assign w_pend[g] = w_pend_flat[g*PEND_W +: PEND_W];
  end

  // flush wins over fire: the dropped instruction never claims its rd.
  assign w_fire   = r_out_vld & out_ready & ~flush;
  assign w_inc    = w_fire & r_rd_we & (r_rd != '0);
  assign in_ready = ~flush & ((r_state == ST_EMPTY) | ((r_state == ST_ISSUE) & out_ready));
  assign w_accept = in_valid & in_ready;

  assign rf_raddr1 = r_rs1;
  assign rf_raddr2 = r_rs2;
  assign out_valid = r_out_vld;
  assign out_src1  = r_src1;
  assign out_src2  = r_src2;
  assign out_rd    = r_rd;
  assign out_rd_we = r_rd_we;

  // Bypass matching; iterating upward lets the highest port win.
  always_comb begin
    w_hit1 = 1'b0; w_hit2 = 1'b0; w_rd_dec = 1'b0;
    w_bdat1 = '0;  w_bdat2 = '0;
    for (int k = 0; k < BYP_PORTS; k++) begin
      if (byp_valid[k]) begin
        if (byp_rd[k*RIDX_W +: RIDX_W] == r_rs1) begin
          w_hit1 = 1'b1; w_bdat1 = byp_data[k*XLEN +: XLEN];
        end
        if (byp_rd[k*RIDX_W +: RIDX_W] == r_rs2) begin
          w_hit2 = 1'b1; w_bdat2 = byp_data[k*XLEN +: XLEN];
        end
        if (byp_rd[k*RIDX_W +: RIDX_W] == r_rd) w_rd_dec = 1'b1;
      end
    end
  end

  // A bypass is only trusted when it is the last outstanding write (pend==1);
  // with more in flight the value on the port would be stale for this reader.
  always_comb begin
    w_ok1 = 1'b0; w_val1 = '0;
    if (r_got1)                                         begin w_ok1 = 1'b1; w_val1 = r_src1;    end
    else if (r_rs1 == '0)                                     w_ok1 = 1'b1;
    else if (!w_busy[r_rs1])                            begin w_ok1 = 1'b1; w_val1 = rf_rdata1; end
    else if (w_pend[r_rs1] == PEND_W'(1) && w_hit1)     begin w_ok1 = 1'b1; w_val1 = w_bdat1;   end

    w_ok2 = 1'b0; w_val2 = '0;
    if (r_got2)                                         begin w_ok2 = 1'b1; w_val2 = r_src2;    end
    else if (r_src2_imm)                                begin w_ok2 = 1'b1; w_val2 = r_imm;     end
    else if (r_rs2 == '0)                                     w_ok2 = 1'b1;
    else if (!w_busy[r_rs2])                            begin w_ok2 = 1'b1; w_val2 = rf_rdata2; end
    else if (w_pend[r_rs2] == PEND_W'(1) && w_hit2)     begin w_ok2 = 1'b1; w_val2 = w_bdat2;   end
  end

  // rd counter must have headroom for this issue; any retire on rd this cycle frees one slot.
  assign w_rd_ok = ~r_rd_we | (r_rd == '0) | ~w_sat[r_rd] | w_rd_dec;
  assign w_go    = w_ok1 & w_ok2 & w_rd_ok;
  assign stall   = (r_state == ST_WAIT) & ~w_go;

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_accept) w_state_nxt = ST_WAIT;
        ST_WAIT:  if (w_go)     w_state_nxt = ST_ISSUE;
        ST_ISSUE: if (w_fire)   w_state_nxt = w_accept ? ST_WAIT : ST_EMPTY;
        default:                w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_EMPTY;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_vld <= 1'b0;
      r_rs1 <= '0; r_rs2 <= '0; r_rd <= '0; r_rd_we <= 1'b0;
      r_imm <= '0; r_src2_imm <= 1'b0;
      r_got1 <= 1'b0; r_got2 <= 1'b0;
      r_src1 <= '0; r_src2 <= '0;
    end else begin
      r_out_vld <= (w_state_nxt == ST_ISSUE);
      if (w_accept) begin
        r_rs1 <= in_rs1; r_rs2 <= in_rs2; r_rd <= in_rd; r_rd_we <= in_rd_we;
        r_imm <= in_imm; r_src2_imm <= in_src2_imm;
        r_got1 <= 1'b0; r_got2 <= 1'b0;
      end else if (r_state == ST_WAIT) begin
        if (!r_got1 && w_ok1) begin r_got1 <= 1'b1; r_src1 <= w_val1; end
        if (!r_got2 && w_ok2) begin r_got2 <= 1'b1; r_src2 <= w_val2; end
      end
    end
  end

  idu_pending_table #(
    .NREG(NREG), .RIDX_W(RIDX_W), .BYP_PORTS(BYP_PORTS), .PEND_W(PEND_W)
  ) u_pend (
    .i_clk(clk), .i_rst(rst),
    .i_inc_vld(w_inc), .i_inc_rd(r_rd),
    .i_dec_vld(byp_valid), .i_dec_rd(byp_rd),
    .o_pend(w_pend_flat), .o_busy(w_busy), .o_sat(w_sat)
  );

endmodule

// File: tb/tb_idu_scoreboard_issue.sv
// Randomized bench for idu_scoreboard_issue against a transaction-level reference model.
// The bench plays decode, regfile and EXU/writeback: every issued write is later retired on a bypass port.
module tb_idu_scoreboard_issue;

  localparam int XLEN = 32, NREG = 32, RIDX_W = 5, BYP = 2, PEND_W = 2;
  localparam int PMAX = 3;
  localparam int NCYC = 4000;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid, in_ready, in_rd_we, in_src2_imm;
  logic [RIDX_W-1:0]      in_rs1, in_rs2, in_rd, rf_raddr1, rf_raddr2, out_rd;
  logic [XLEN-1:0]        in_imm, rf_rdata1, rf_rdata2, out_src1, out_src2;
  logic [BYP-1:0]         byp_valid;
  logic [BYP*RIDX_W-1:0]  byp_rd;
  logic [BYP*XLEN-1:0]    byp_data;
  logic                   flush, out_valid, out_ready, out_rd_we, stall;

  always #5 clk = ~clk;

  idu_scoreboard_issue #(
    .XLEN(XLEN), .NREG(NREG), .RIDX_W(RIDX_W), .BYP_PORTS(BYP), .PEND_W(PEND_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_we(in_rd_we),
    .in_imm(in_imm), .in_src2_imm(in_src2_imm),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .byp_valid(byp_valid), .byp_rd(byp_rd), .byp_data(byp_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_src1(out_src1), .out_src2(out_src2), .out_rd(out_rd), .out_rd_we(out_rd_we),
    .stall(stall)
  );

  // Architectural register file owned by the bench.
  logic [XLEN-1:0] rf_m [NREG];
  assign rf_rdata1 = rf_m[rf_raddr1];
  assign rf_rdata2 = rf_m[rf_raddr2];

  // Reference model: outstanding writes per register plus the one held instruction.
  int              m_pend [NREG];
  bit              m_held, m_issued, m_got1, m_got2, m_we, m_s2i;
  int              m_rs1, m_rs2, m_rd;
  logic [XLEN-1:0] m_imm, m_v1, m_v2;

  // Predictions for the current cycle.
  bit              e_ok1, e_ok2, e_go, e_fire, e_acc, e_inrdy;
  logic [XLEN-1:0] e_v1, e_v2;

  int n_chk = 0, n_fail = 0;

  task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int retires_on(input int r);
    int n = 0;
    for (int k = 0; k < BYP; k++)
      if (byp_valid[k] && int'(byp_rd[k*RIDX_W +: RIDX_W]) == r) n++;
    return n;
  endfunction

  // Operand availability rule: x0 is zero, no outstanding write reads the regfile,
  // exactly one outstanding write may be caught on a port (highest port wins).
  task automatic resolve_src(input int r, output bit ok, output logic [XLEN-1:0] v);
    ok = 1'b0; v = '0;
    if (r == 0) ok = 1'b1;
    else if (m_pend[r] == 0) begin ok = 1'b1; v = rf_m[r]; end
    else if (m_pend[r] == 1) begin
      for (int k = 0; k < BYP; k++)
        if (byp_valid[k] && int'(byp_rd[k*RIDX_W +: RIDX_W]) == r) begin
          ok = 1'b1; v = byp_data[k*XLEN +: XLEN];
        end
    end
  endtask

  task automatic predict();
    bit rd_ok;
    if (m_got1) begin e_ok1 = 1'b1; e_v1 = m_v1; end
    else resolve_src(m_rs1, e_ok1, e_v1);
    if (m_got2)     begin e_ok2 = 1'b1; e_v2 = m_v2;  end
    else if (m_s2i) begin e_ok2 = 1'b1; e_v2 = m_imm; end
    else resolve_src(m_rs2, e_ok2, e_v2);
    rd_ok   = !m_we || m_rd == 0 || (m_pend[m_rd] - retires_on(m_rd)) < PMAX;
    e_go    = e_ok1 && e_ok2 && rd_ok;
    e_inrdy = !flush && (!m_held || (m_issued && out_ready));
    e_fire  = m_issued && out_ready && !flush;
    e_acc   = in_valid && e_inrdy;
  endtask

  task automatic check_outputs();
    chk_eq("in_ready", in_ready, e_inrdy);
    chk_eq("out_valid", out_valid, m_issued);
    chk_eq("stall", stall, m_held && !m_issued && !e_go);
    if (m_issued) begin
      chk_eq("out_src1", out_src1, m_v1);
      chk_eq("out_src2", out_src2, m_v2);
      chk_eq("out_rd", out_rd, m_rd);
      chk_eq("out_rd_we", out_rd_we, m_we);
    end
  endtask

  task automatic commit();
    if (flush) begin
      m_held = 1'b0; m_issued = 1'b0;
    end else if (m_issued) begin
      if (e_fire) begin m_held = 1'b0; m_issued = 1'b0; end
    end else if (m_held) begin
      if (!m_got1 && e_ok1) begin m_got1 = 1'b1; m_v1 = e_v1; end
      if (!m_got2 && e_ok2) begin m_got2 = 1'b1; m_v2 = e_v2; end
      if (e_go) m_issued = 1'b1;
    end
    for (int k = 0; k < BYP; k++) begin
      int r = int'(byp_rd[k*RIDX_W +: RIDX_W]);
      if (byp_valid[k] && r != 0) begin
        m_pend[r]--;
        rf_m[r] = byp_data[k*XLEN +: XLEN];
      end
    end
    if (e_fire && m_we && m_rd != 0) m_pend[m_rd]++;
    if (e_acc) begin
      m_held = 1'b1; m_issued = 1'b0; m_got1 = 1'b0; m_got2 = 1'b0;
      m_rs1 = int'(in_rs1); m_rs2 = int'(in_rs2); m_rd = int'(in_rd);
      m_we = in_rd_we; m_imm = in_imm; m_s2i = in_src2_imm;
    end
  endtask

  task automatic chk_pend();
    for (int r = 0; r < NREG; r++)
      chk_eq("pend_count", dut.u_pend.o_pend[r*PEND_W +: PEND_W], m_pend[r]);
  endtask

  task automatic drive(input int cyc);
    int                    avail [NREG];
    int                    q[$];
    int                    pick, prev, pct;
    logic [BYP-1:0]        v;
    logic [BYP*RIDX_W-1:0] rds;
    logic [BYP*XLEN-1:0]   ds;
    for (int r = 0; r < NREG; r++) avail[r] = m_pend[r];
    // Alternate busy-retire and slow-retire phases so counters reach saturation.
    pct = ((cyc / 400) % 2 == 1) ? 12 : 50;
    v = '0; rds = '0; ds = '0; prev = -1;
    for (int k = 0; k < BYP; k++) begin
      ds[k*XLEN +: XLEN] = $urandom;
      if ($urandom_range(0, 99) < pct) begin
        q.delete();
        for (int r = 1; r < NREG; r++) if (avail[r] > 0) q.push_back(r);
        if (q.size() > 0) begin
          pick = q[$urandom_range(0, q.size() - 1)];
          if (prev > 0 && avail[prev] > 0 && $urandom_range(0, 1) == 1) pick = prev;
          avail[pick]--; v[k] = 1'b1; rds[k*RIDX_W +: RIDX_W] = RIDX_W'(pick); prev = pick;
        end
      end else if ($urandom_range(0, 15) == 0) begin
        v[k] = 1'b1;   // retire activity on x0 must be ignored
      end
    end
    byp_valid = v; byp_rd = rds; byp_data = ds;
    flush       = m_held && ($urandom_range(0, 99) < 3);
    out_ready   = ($urandom_range(0, 3) != 0);
    in_valid    = ($urandom_range(0, 9) < 7);
    in_rs1      = RIDX_W'($urandom_range(0, 7));
    in_rs2      = RIDX_W'($urandom_range(0, 7));
    in_rd       = RIDX_W'($urandom_range(0, 7));
    in_rd_we    = ($urandom_range(0, 3) != 0);
    in_imm      = $urandom;
    in_src2_imm = ($urandom_range(0, 3) == 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; byp_valid = '0; byp_rd = '0; byp_data = '0;
    flush = 1'b0; out_ready = 1'b0;
    in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_rd_we = 1'b0; in_imm = '0; in_src2_imm = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    for (int r = 0; r < NREG; r++) m_pend[r] = 0;
    m_held = 1'b0; m_issued = 1'b0; m_got1 = 1'b0; m_got2 = 1'b0;
    chk_eq("rst_in_ready", in_ready, 1'b1);
    chk_eq("rst_out_valid", out_valid, 1'b0);
    chk_eq("rst_stall", stall, 1'b0);
    chk_eq("rst_out_src1", out_src1, 0);
    chk_eq("rst_out_src2", out_src2, 0);
    chk_eq("rst_out_rd", out_rd, 0);
    chk_eq("rst_out_rd_we", out_rd_we, 1'b0);
    chk_pend();
    rst = 1'b0;
  endtask

  initial begin
    m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_we = 1'b0; m_s2i = 1'b0;
    m_imm = '0; m_v1 = '0; m_v2 = '0;
    rf_m[0] = '0;
    for (int r = 1; r < NREG; r++) rf_m[r] = $urandom;
    rf_m[1] = 32'd5; rf_m[2] = 32'd7;
    do_reset();
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      if (cyc == NCYC / 2) begin
        @(negedge clk);
        do_reset();   // reset in the middle of traffic
      end else begin
        @(negedge clk);
        drive(cyc);
        #1;
        predict();
        check_outputs();
        @(posedge clk);
        #1;
        commit();
        if (cyc % 256 == 255) chk_pend();
      end
    end
    chk_pend();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
